// File: rtl/vga_marker_overlay_if.sv
// Fetch bus between the VGA scan-out stage (master) and the memory arbiter (slave).
// Requests are one-cycle pulses; the word comes back with fetch_valid at most MEM_LAT cycles later.
interface vga_marker_overlay_if;
  logic        fetch_req;
  logic [9:0]  fetch_hcount;
  logic [9:0]  fetch_vcount;
  logic [35:0] fetch_word;
  logic        fetch_valid;

  modport master (
    output fetch_req, fetch_hcount, fetch_vcount,
    input  fetch_word, fetch_valid
  );

  modport slave (
    input  fetch_req, fetch_hcount, fetch_vcount,
    output fetch_word, fetch_valid
  );
endinterface

// File: rtl/vga_marker_overlay.sv
// VGA scan-out: timing, word fetch, YCrCb unpack, marker overlay. Counter->pins MEM_LAT+3 cycles;
// no backpressure (a late word is shown black, flags underflow). Define VGA_CENTER_CROSS_EN for centre lines.
module vga_marker_overlay #(
  parameter int          H_ACTIVE = 640,
  parameter int          H_FP     = 16,
  parameter int          H_SYNC   = 96,
  parameter int          H_BP     = 48,
  parameter int          V_ACTIVE = 480,
  parameter int          V_FP     = 11,
  parameter int          V_SYNC   = 2,
  parameter int          V_BP     = 31,
  parameter int          MEM_LAT  = 2,
  parameter int          N_MARK   = 4,
  parameter int          ARM      = 8,
  parameter logic [23:0] MARK_RGB = 24'hFFFFFF
) (
  input  logic                     clock,
  input  logic                     reset,
  vga_marker_overlay_if.master     fetch,
  input  logic [1:0]               mark_mode,
  input  logic [N_MARK-1:0]        mark_en,
  input  logic [10*N_MARK-1:0]     mark_x,
  input  logic [9*N_MARK-1:0]      mark_y,
  output logic                     underflow,
  output logic [7:0]               vga_out_red,
  output logic [7:0]               vga_out_green,
  output logic [7:0]               vga_out_blue,
  output logic                     vga_out_hsync,
  output logic                     vga_out_vsync,
  output logic                     vga_out_blank_b
);
  localparam int DEPTH = MEM_LAT + 2;
  localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic signed [10:0] ARM_S = 11'(ARM);

  typedef struct packed {
    logic [9:0] h;
    logic [9:0] v;
    logic       hs;
    logic       vs;
    logic       blank;
  } tinfo_t;

  localparam tinfo_t TINFO_IDLE = '{h: 10'd0, v: 10'd0, hs: 1'b1, vs: 1'b1, blank: 1'b1};

  function automatic logic [7:0] clamp8(input logic signed [10:0] c);
    if (c < 11'sd0)        return 8'd0;
    else if (c > 11'sd255) return 8'd255;
    else                   return c[7:0];
  endfunction

  // Y in [17:10], Cr in [9:5], Cb in [4:0]; chroma is offset-16 and scaled x8 before mixing.
  function automatic logic [23:0] ycrcb_lut(input logic [17:0] p);
    logic signed [10:0] y, crs, cbs, r, g, b;
    y   = $signed({3'b000, p[17:10]});
    crs = $signed({3'b000, p[9:5], 3'b000}) - 11'sd128;
    cbs = $signed({3'b000, p[4:0], 3'b000}) - 11'sd128;
    r   = y + crs + (crs >>> 1);
    g   = y - (cbs >>> 2) - (crs >>> 1);
    b   = y + (cbs <<< 1);
    return {clamp8(r), clamp8(g), clamp8(b)};
  endfunction

  // Differences are taken in 11-bit signed so a marker near an edge never wraps to the far side.
  function automatic logic mark_hit(input logic [1:0] mode, input logic [9:0] h, input logic [9:0] v,
                                    input logic [9:0] x, input logic [8:0] y);
    logic signed [10:0] dx, dy;
    logic               near_x, near_y;
    dx     = $signed({1'b0, h}) - $signed({1'b0, x});
    dy     = $signed({1'b0, v}) - $signed({2'b00, y});
    near_x = (dx <= ARM_S) && (dx >= -ARM_S);
    near_y = (dy <= ARM_S) && (dy >= -ARM_S);
    case (mode)
      2'd1:    return (h == x) || (v == {1'b0, y});
      2'd2:    return (near_x && (v == {1'b0, y})) || (near_y && (h == x));
      default: return 1'b0;
    endcase
  endfunction

  logic [9:0]                hcount_q, hcount_d, vcount_q, vcount_d;
  tinfo_t [DEPTH-1:0]        pipe_q, pipe_d;
  tinfo_t                    stage0, d;
  logic                      fetch_req_q, fetch_req_d;
  logic [9:0]                fetch_hcount_q, fetch_hcount_d, fetch_vcount_q, fetch_vcount_d;
  logic [MEM_LAT-1:0]        req_hist_q, req_hist_d;
  logic [35:0]               hold_q, hold_d;
  logic                      word_ok_q, word_ok_d;
  logic [17:0]               odd_q, odd_d;
  logic                      odd_black_q, odd_black_d;
  logic                      underflow_q, underflow_d;
  logic [23:0]               rgb_q, rgb_d;
  logic                      hsync_q, hsync_d, vsync_q, vsync_d, blank_b_q, blank_b_d;
  logic                      consume_even, pix_black, any_hit;
  logic [17:0]               pix;

  always_comb begin
    hcount_d = hcount_q + 10'd1;
    vcount_d = vcount_q;
    if (hcount_q == H_LAST) begin
      hcount_d = 10'd0;
      vcount_d = (vcount_q == V_LAST) ? 10'd0 : vcount_q + 10'd1;
    end

    stage0.h     = hcount_q;
    stage0.v     = vcount_q;
    stage0.hs    = !((hcount_q >= HS_START) && (hcount_q < HS_END));
    stage0.vs    = !((vcount_q >= VS_START) && (vcount_q < VS_END));
    stage0.blank = (hcount_q >= H_ACT) || (vcount_q >= V_ACT);

    fetch_req_d    = !stage0.blank && !hcount_q[0];
    fetch_hcount_d = fetch_req_d ? hcount_q : fetch_hcount_q;
    fetch_vcount_d = fetch_req_d ? vcount_q : fetch_vcount_q;
    pipe_d         = {pipe_q[DEPTH-2:0], stage0};
    d              = pipe_q[DEPTH-1];
  end

  // A returned word only counts as delivered if a request went out within the last MEM_LAT cycles.
  always_comb begin
    req_hist_d   = (req_hist_q << 1) | MEM_LAT'(fetch_req_q);
    consume_even = !d.blank && !d.h[0];
    hold_d       = fetch.fetch_valid ? fetch.fetch_word : hold_q;
    word_ok_d    = word_ok_q;
    if (consume_even)
      word_ok_d = 1'b0;
    if (fetch.fetch_valid && (|req_hist_q))
      word_ok_d = 1'b1;
    odd_d        = consume_even ? hold_q[35:18] : odd_q;
    odd_black_d  = consume_even ? !word_ok_q : odd_black_q;
    underflow_d  = underflow_q | (consume_even & !word_ok_q);
    pix          = d.h[0] ? odd_q : hold_q[17:0];
    pix_black    = d.h[0] ? odd_black_q : !word_ok_q;
  end

  always_comb begin
    any_hit = 1'b0;
    for (int i = 0; i < N_MARK; i++)
      if (mark_en[i] && mark_hit(mark_mode, d.h, d.v, mark_x[10*i +: 10], mark_y[9*i +: 9]))
        any_hit = 1'b1;

    rgb_d = 24'h000000;
    if (d.blank)
      rgb_d = 24'h000000;
    else if (any_hit)
      rgb_d = MARK_RGB;
`ifdef VGA_CENTER_CROSS_EN
    else if ((d.h == 10'(H_ACTIVE / 2)) || (d.v == 10'(V_ACTIVE / 2)))
      rgb_d = 24'hFFFFFF;
`endif
    else if (!pix_black)
      rgb_d = ycrcb_lut(pix);

    hsync_d   = d.hs;
    vsync_d   = d.vs;
    blank_b_d = !d.blank;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hcount_q       <= 10'd0;
      vcount_q       <= 10'd0;
      pipe_q         <= {DEPTH{TINFO_IDLE}};
      fetch_req_q    <= 1'b0;
      fetch_hcount_q <= 10'd0;
      fetch_vcount_q <= 10'd0;
      req_hist_q     <= '0;
      hold_q         <= 36'd0;
      word_ok_q      <= 1'b0;
      odd_q          <= 18'd0;
      odd_black_q    <= 1'b1;
      underflow_q    <= 1'b0;
      rgb_q          <= 24'h000000;
      hsync_q        <= 1'b1;
      vsync_q        <= 1'b1;
      blank_b_q      <= 1'b0;
    end else begin
      hcount_q       <= hcount_d;
      vcount_q       <= vcount_d;
      pipe_q         <= pipe_d;
      fetch_req_q    <= fetch_req_d;
      fetch_hcount_q <= fetch_hcount_d;
      fetch_vcount_q <= fetch_vcount_d;
      req_hist_q     <= req_hist_d;
      hold_q         <= hold_d;
      word_ok_q      <= word_ok_d;
      odd_q          <= odd_d;
      odd_black_q    <= odd_black_d;
      underflow_q    <= underflow_d;
      rgb_q          <= rgb_d;
      hsync_q        <= hsync_d;
      vsync_q        <= vsync_d;
      blank_b_q      <= blank_b_d;
    end
  end

  assign fetch.fetch_req    = fetch_req_q;
  assign fetch.fetch_hcount = fetch_hcount_q;
  assign fetch.fetch_vcount = fetch_vcount_q;
  assign underflow          = underflow_q;
  assign vga_out_red        = rgb_q[23:16];
  assign vga_out_green      = rgb_q[15:8];
  assign vga_out_blue       = rgb_q[7:0];
  assign vga_out_hsync      = hsync_q;
  assign vga_out_vsync      = vsync_q;
  assign vga_out_blank_b    = blank_b_q;
endmodule

// File: tb/tb_vga_marker_overlay.sv
// Randomised bench for vga_marker_overlay: scan position is derived from the cycle count since reset,
// and every pin is predicted from the scan rules, a memory model and a marker model.
module tb_vga_marker_overlay;
  localparam int H_ACTIVE = 160, H_FP = 8, H_SYNC = 16, H_BP = 8;
  localparam int V_ACTIVE = 40,  V_FP = 3, V_SYNC = 2,  V_BP = 5;
  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int MEM_LAT = 2, N_MARK = 4, ARM = 8;
  localparam int LAT = MEM_LAT + 3;
  localparam int DROP_H = 100;
  localparam logic [23:0] MARK_RGB = 24'hFFFFFF;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [1:0]              mark_mode;
  logic [N_MARK-1:0]       mark_en;
  logic [10*N_MARK-1:0]    mark_x;
  logic [9*N_MARK-1:0]     mark_y;
  logic                    underflow;
  logic [7:0]              vga_out_red, vga_out_green, vga_out_blue;
  logic                    vga_out_hsync, vga_out_vsync, vga_out_blank_b;

  vga_marker_overlay_if fbus();

  vga_marker_overlay #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .MEM_LAT(MEM_LAT), .N_MARK(N_MARK), .ARM(ARM), .MARK_RGB(MARK_RGB)
  ) dut (
    .clock(clock), .reset(reset), .fetch(fbus),
    .mark_mode(mark_mode), .mark_en(mark_en), .mark_x(mark_x), .mark_y(mark_y),
    .underflow(underflow),
    .vga_out_red(vga_out_red), .vga_out_green(vga_out_green), .vga_out_blue(vga_out_blue),
    .vga_out_hsync(vga_out_hsync), .vga_out_vsync(vga_out_vsync), .vga_out_blank_b(vga_out_blank_b)
  );

  always #5 clock = ~clock;

  int          n_checks = 0;
  int          n_fail = 0;
  int          n = 0;
  int          cyc = 0;
  int          dropped[$];
  bit          uf_exp = 1'b0;
  bit          drop_arm = 1'b0;
  bit          mv[2];
  logic [35:0] mw[2];
  logic [17:0] salt[VT];
  bit          prev_hs = 1'b1, prev_vs = 1'b1;
  int          hs_fall = -1, vs_fall = -1;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d after reset)", tag, obs, exp, n);
    end
  endtask

  // Even lines carry the plain {h+1, h} pattern; odd lines are scrambled to reach the clamps.
  function automatic logic [17:0] pix_val(input int h, input int v);
    if (v < 0 || v >= VT) return 18'd0;
    return (18'h20000 + 18'(h)) ^ salt[v];
  endfunction

  function automatic logic [23:0] lut(input logic [17:0] p);
    int y, cr8, cb8;
    int c[3];
    logic [23:0] res;
    y   = int'(p[17:10]);
    cr8 = (int'(p[9:5]) - 16) * 8;
    cb8 = (int'(p[4:0]) - 16) * 8;
    c[0] = y + cr8 + cr8 / 2;
    c[1] = y - cb8 / 4 - cr8 / 2;
    c[2] = y + 2 * cb8;
    for (int k = 0; k < 3; k++) begin
      if (c[k] < 0)   c[k] = 0;
      if (c[k] > 255) c[k] = 255;
    end
    res = {8'(c[0]), 8'(c[1]), 8'(c[2])};
    return res;
  endfunction

  function automatic bit marker_hit(input logic [1:0] m, input logic [N_MARK-1:0] en,
                                    input logic [10*N_MARK-1:0] xs, input logic [9*N_MARK-1:0] ys,
                                    input int h, input int v);
    int x, y;
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < N_MARK; i++) begin
      if (en[i]) begin
        x = int'(xs[10*i +: 10]);
        y = int'(ys[9*i +: 9]);
        if (m == 2'd1 && (h == x || v == y)) hit = 1'b1;
        if (m == 2'd2 && (((h - x <= ARM) && (x - h <= ARM) && v == y) ||
                          ((v - y <= ARM) && (y - v <= ARM) && h == x))) hit = 1'b1;
      end
    end
    return hit;
  endfunction

  task automatic check_cycle(input logic [1:0] um, input logic [N_MARK-1:0] ue,
                             input logic [10*N_MARK-1:0] ux, input logic [9*N_MARK-1:0] uy);
    int p, h, v, pf, hf, vf;
    bit act, exp_hs, exp_vs, drp, exp_req;
    logic [23:0] rgb;
    pf = n - 1;
    hf = pf % HT;
    vf = (pf / HT) % VT;
    exp_req = (hf < H_ACTIVE) && (vf < V_ACTIVE) && (hf % 2 == 0);
    check_eq("fetch_req", 64'(fbus.fetch_req), 64'(exp_req));
    if (exp_req)
      check_eq("fetch_addr", 64'({fbus.fetch_vcount, fbus.fetch_hcount}), 64'(vf * 1024 + hf));

    p = n - LAT;
    rgb = 24'h0; exp_hs = 1'b1; exp_vs = 1'b1; act = 1'b0;
    if (p >= 0) begin
      h = p % HT;
      v = (p / HT) % VT;
      act    = (h < H_ACTIVE) && (v < V_ACTIVE);
      exp_hs = !(h >= H_ACTIVE + H_FP && h < H_ACTIVE + H_FP + H_SYNC);
      exp_vs = !(v >= V_ACTIVE + V_FP && v < V_ACTIVE + V_FP + V_SYNC);
      drp = 1'b0;
      foreach (dropped[k]) if (p == dropped[k] || p == dropped[k] + 1) drp = 1'b1;
      if (act) begin
        if (drp) uf_exp = 1'b1;
        if (marker_hit(um, ue, ux, uy, h, v)) rgb = MARK_RGB;
`ifdef VGA_CENTER_CROSS_EN
        else if (h == H_ACTIVE / 2 || v == V_ACTIVE / 2) rgb = 24'hFFFFFF;
`endif
        else if (!drp) rgb = lut(pix_val(h, v));
      end
    end
    check_eq("pins", 64'({vga_out_red, vga_out_green, vga_out_blue, vga_out_hsync, vga_out_vsync,
                          vga_out_blank_b, underflow}),
             64'({rgb, exp_hs, exp_vs, act, uf_exp}));

    if (prev_hs && !vga_out_hsync) begin
      if (hs_fall >= 0) check_eq("hs_period", 64'(cyc - hs_fall), 64'(HT));
      hs_fall = cyc;
    end
    if (!prev_hs && vga_out_hsync && hs_fall >= 0) check_eq("hs_low", 64'(cyc - hs_fall), 64'(H_SYNC));
    if (prev_vs && !vga_out_vsync) begin
      if (vs_fall >= 0) check_eq("vs_period", 64'(cyc - vs_fall), 64'(HT * VT));
      vs_fall = cyc;
    end
    if (!prev_vs && vga_out_vsync && vs_fall >= 0) check_eq("vs_low", 64'(cyc - vs_fall), 64'(HT * V_SYNC));
    prev_hs = vga_out_hsync;
    prev_vs = vga_out_vsync;
  endtask

  // Memory returns the requested pair two cycles after the request is seen, except an armed drop.
  task automatic memory_cycle();
    bit ov;
    logic [35:0] ow;
    int h, v;
    ov = mv[1]; ow = mw[1];
    mv[1] = mv[0]; mw[1] = mw[0];
    mv[0] = 1'b0; mw[0] = 36'd0;
    if (fbus.fetch_req) begin
      h = int'(fbus.fetch_hcount);
      v = int'(fbus.fetch_vcount);
      if (drop_arm && h == DROP_H) begin
        drop_arm = 1'b0;
        dropped.push_back(n - 1);
      end else begin
        mv[0] = 1'b1;
        mw[0] = {pix_val(h + 1, v), pix_val(h, v)};
      end
    end
    fbus.fetch_valid = ov;
    fbus.fetch_word  = ov ? ow : {4'($urandom), 32'($urandom)};
  endtask

  task automatic step();
    logic [1:0] um; logic [N_MARK-1:0] ue; logic [10*N_MARK-1:0] ux; logic [9*N_MARK-1:0] uy;
    um = mark_mode; ue = mark_en; ux = mark_x; uy = mark_y;
    @(posedge clock);
    #1;
    cyc++;
    if (!reset) begin
      n++;
      check_cycle(um, ue, ux, uy);
      memory_cycle();
    end else begin
      mv[0] = 1'b0; mv[1] = 1'b0;
      fbus.fetch_valid = 1'b0;
    end
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) step();
  endtask

  task automatic apply_reset(input int cycles);
    reset = 1'b1;
    #1;
    check_eq("rst_pins", 64'({vga_out_red, vga_out_green, vga_out_blue, vga_out_hsync, vga_out_vsync,
                              vga_out_blank_b, underflow}), 64'({24'h0, 1'b1, 1'b1, 1'b0, 1'b0}));
    check_eq("rst_fetch", 64'({fbus.fetch_req, fbus.fetch_hcount, fbus.fetch_vcount}), 64'd0);
    dropped.delete();
    uf_exp = 1'b0; drop_arm = 1'b0;
    mv[0] = 1'b0; mv[1] = 1'b0;
    fbus.fetch_valid = 1'b0;
    run(cycles);
    reset = 1'b0;
    n = 0;
    prev_hs = 1'b1; prev_vs = 1'b1; hs_fall = -1; vs_fall = -1;
  endtask

  task automatic set_mark(input int ch, input int x, input int y);
    mark_x[10*ch +: 10] = 10'(x);
    mark_y[9*ch +: 9]   = 9'(y);
  endtask

  initial begin
    int guard;
    mark_mode = 2'd0; mark_en = '0; mark_x = '0; mark_y = '0;
    fbus.fetch_valid = 1'b0; fbus.fetch_word = 36'd0;
    for (int v = 0; v < VT; v++) salt[v] = (v % 2 == 1) ? 18'($urandom) : 18'd0;
    #2;
    apply_reset(3);

    // Two plain frames with markers disabled by mode.
    mark_en = '1; set_mark(0, 80, 20);
    run(2 * HT * VT);
    check_eq("no_underflow", 64'(underflow), 64'd0);

    drop_arm = 1'b1;
    run(3 * HT);
    check_eq("underflow_set", 64'(underflow), 64'd1);
    run(HT * VT / 2);
    check_eq("underflow_sticky", 64'(underflow), 64'd1);

    mark_mode = 2'd1; mark_en = 4'b0001; set_mark(0, 80, 20);
    run(HT * VT);
    mark_en = 4'b0000;
    run(3000);

    mark_mode = 2'd2; mark_en = 4'b0100; set_mark(2, 3, 5);
    run(HT * VT);

    for (int s = 0; s < 10; s++) begin
      mark_mode = 2'($urandom_range(0, 3));
      mark_en   = 4'($urandom);
      for (int c = 0; c < N_MARK; c++)
        set_mark(c, $urandom_range(0, H_ACTIVE + 10), $urandom_range(0, V_ACTIVE + 5));
      run(1200);
    end

    // Reset mid-line while underflow is still set.
    guard = 0;
    while (!((n % HT) == 120 && ((n / HT) % VT) < V_ACTIVE) && guard < 2 * HT * VT) begin
      step();
      guard++;
    end
    if (guard >= 2 * HT * VT) check_eq("reset_wait", 64'd0, 64'd1);
    check_eq("pre_reset_underflow", 64'(underflow), 64'd1);
    apply_reset(3);
    run(3000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
